// File: rtl/multi_bit_sync_filter.sv
// Multi-channel synchroniser with per-channel debounce filter and optional
// rise/fall/change event outputs (enabled by MULTI_BIT_SYNC_EVENT_EN).
module multi_bit_sync_filter #(
  parameter int NUM_STG  = 2,
  parameter int WIDTH    = 4,
  parameter int FILT_LEN = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             chg_o
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [WIDTH-1:0] event_any;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    logic [NUM_STG-1:0] chain_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               level_q, level_d;
    logic               s;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) chain_q <= '0;
      else       chain_q <= {chain_q[NUM_STG-2:0], async_i[gi]};
    end

    assign s = chain_q[NUM_STG-1];

    // Any agreeing cycle restarts the count; only an unbroken run commits.
    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (s != level_q) begin
        if (cnt_q == CNT_LAST) level_d = s;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    assign sync_o[gi] = level_q;

`ifdef MULTI_BIT_SYNC_EVENT_EN
    logic rise_q, fall_q;

    // Registered alongside level so the pulse lines up with the new sync value.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= level_d & ~level_q;
        fall_q <= ~level_d & level_q;
      end
    end

    assign rise_o[gi]    = rise_q;
    assign fall_o[gi]    = fall_q;
    assign event_any[gi] = rise_q | fall_q;
`else
    assign rise_o[gi]    = 1'b0;
    assign fall_o[gi]    = 1'b0;
    assign event_any[gi] = 1'b0;
`endif
  end

`ifdef MULTI_BIT_SYNC_EVENT_EN
  logic chg_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) chg_q <= 1'b0;
    else       chg_q <= |event_any;
  end

  assign chg_o = chg_q;
`else
  logic unused_events;
  assign unused_events = |event_any;
  assign chg_o = 1'b0;
`endif

endmodule
